// File: rtl/ysyx_22040237_lsu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_lsu_pkg
// Shared definitions for the load/store unit: bit positions inside the
// execute-stage LS info bus, FSM state encodings and the access-size code
// passed between the top module and the load-data extractor.
// ---------------------------------------------------------------------------
package ysyx_22040237_lsu_pkg;

  // Bit positions inside ls_info_bus_i.
  localparam int LS_LOAD  = 0;
  localparam int LS_STORE = 1;
  localparam int LS_USIGN = 2;
  localparam int LS_BYTE  = 3;
  localparam int LS_HALF  = 4;
  localparam int LS_WORD  = 5;
  localparam int LS_DW    = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Access size as log2(bytes).
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

endpackage

// File: rtl/ysyx_22040237_lsu_ext.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_lsu_ext
// Combinational load-data extraction: moves the addressed byte lane of a
// 64-bit memory word down to bit 0, truncates to the access size and sign-
// or zero-extends back to XLEN. Double-word accesses ignore usign.
// Ports:
//   rdata  in  XLEN  raw memory read data (aligned 8-byte line)
//   offset in  3     byte offset of the access within the line
//   size   in  2     access size code (lsu_size_e)
//   usign  in  1     1 = zero-extend, 0 = sign-extend
//   data   out XLEN  extended load result
// ---------------------------------------------------------------------------
module ysyx_22040237_lsu_ext
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [1:0]      size,
  input  logic            usign,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path through the case leaves it holding a stale value
  // (which would infer a latch).
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (size)
      SZ_B: data = usign ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                         : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      SZ_H: data = usign ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                         : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      SZ_W: data = usign ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                         : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      SZ_D: data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22040237_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_lsu
// Multi-cycle load/store unit. Takes a load/store from execute, issues one
// valid/ready request on a 64-bit data-memory port, waits for the response
// and returns extended load data with the destination register. Illegal or
// misaligned accesses skip memory and complete with a one-cycle err_o.
// Ports:
//   clk, rst                     core clock, synchronous active-high reset
//   ls_valid_i, ls_info_bus_i    request qualifier and {dw,word,half,byte,
//                                usign,store,load}
//   addr_i, wdata_i              effective address, right-aligned store data
//   rd_wr_en_i, rd_idx_i         destination passthrough
//   stall_o                      hold fetch/decode/execute
//   wb_valid_o, err_o            one-cycle completion / error pulses
//   rd_wr_en_o, rd_idx_o         registered destination
//   wb_data_o                    extended load data (0 for stores)
//   mem_req_*                    request: valid/ready, we, line address,
//                                lane-shifted wdata, byte strobes
//   mem_rsp_valid_i/rdata_i      response (also acknowledges writes)
// ---------------------------------------------------------------------------
module ysyx_22040237_lsu
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ls_valid_i,
  input  logic [6:0]      ls_info_bus_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            rd_wr_en_i,
  input  logic [4:0]      rd_idx_i,
  output logic            stall_o,
  output logic            wb_valid_o,
  output logic            rd_wr_en_o,
  output logic [4:0]      rd_idx_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            err_o,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic            mem_req_we_o,
  output logic [XLEN-1:0] mem_req_addr_o,
  output logic [XLEN-1:0] mem_req_wdata_o,
  output logic [7:0]      mem_req_wstrb_o,
  input  logic            mem_rsp_valid_i,
  input  logic [XLEN-1:0] mem_rsp_rdata_i
);

  lsu_state_e state;
  lsu_size_e  size_q;
  logic [2:0] offset_q;
  logic       usign_q;
  logic       rd_wr_en_q;

  // Request decode, only meaningful while IDLE.
  logic       is_load, is_store, start, size_ok, illegal, misaligned;
  lsu_size_e  size_d;
  logic [2:0] align_mask;
  logic [7:0] strb_base;

  always_comb begin
    is_load    = ls_info_bus_i[LS_LOAD];
    is_store   = ls_info_bus_i[LS_STORE];
    start      = ls_valid_i & (is_load | is_store);
    size_ok    = 1'b1;
    size_d     = SZ_B;
    align_mask = 3'b000;
    strb_base  = 8'h01;
    // The size field must be strictly one-hot.
    case (ls_info_bus_i[LS_DW:LS_BYTE])
      4'b0001: begin size_d = SZ_B; align_mask = 3'b000; strb_base = 8'h01; end
      4'b0010: begin size_d = SZ_H; align_mask = 3'b001; strb_base = 8'h03; end
      4'b0100: begin size_d = SZ_W; align_mask = 3'b011; strb_base = 8'h0F; end
      4'b1000: begin size_d = SZ_D; align_mask = 3'b111; strb_base = 8'hFF; end
      default: size_ok = 1'b0;
    endcase
    illegal    = ~size_ok | (is_load & is_store);
    misaligned = |(addr_i[2:0] & align_mask);
  end

  // DONE is excluded: the core holds the instruction through DONE and
  // advances on the following cycle when the writeback is consumed.
  assign stall_o = (state == ST_REQ) || (state == ST_RSP) ||
                   ((state == ST_IDLE) && start);

  logic [XLEN-1:0] ext_data;

  ysyx_22040237_lsu_ext #(.XLEN(XLEN)) u_ext (
    .rdata  (mem_rsp_rdata_i),
    .offset (offset_q),
    .size   (size_q),
    .usign  (usign_q),
    .data   (ext_data)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // sees the pre-edge value of every other, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      size_q          <= SZ_B;
      offset_q        <= 3'd0;
      usign_q         <= 1'b0;
      rd_wr_en_q      <= 1'b0;
      wb_valid_o      <= 1'b0;
      err_o           <= 1'b0;
      rd_wr_en_o      <= 1'b0;
      rd_idx_o        <= 5'd0;
      wb_data_o       <= '0;
      mem_req_valid_o <= 1'b0;
      mem_req_we_o    <= 1'b0;
      mem_req_addr_o  <= '0;
      mem_req_wdata_o <= '0;
      mem_req_wstrb_o <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rd_idx_o <= rd_idx_i;
            if (illegal || misaligned) begin
              wb_valid_o <= 1'b1;
              err_o      <= 1'b1;
              rd_wr_en_o <= 1'b0;
              wb_data_o  <= '0;
              state      <= ST_DONE;
            end else begin
              offset_q        <= addr_i[2:0];
              size_q          <= size_d;
              usign_q         <= ls_info_bus_i[LS_USIGN];
              rd_wr_en_q      <= rd_wr_en_i & is_load;
              mem_req_valid_o <= 1'b1;
              mem_req_we_o    <= is_store;
              mem_req_addr_o  <= {addr_i[XLEN-1:3], 3'b000};
              mem_req_wdata_o <= is_store ? (wdata_i << {addr_i[2:0], 3'b000}) : '0;
              mem_req_wstrb_o <= is_store ? (strb_base << addr_i[2:0]) : 8'h00;
              state           <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state           <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (mem_rsp_valid_i) begin
            wb_valid_o <= 1'b1;
            rd_wr_en_o <= rd_wr_en_q;
            wb_data_o  <= mem_req_we_o ? '0 : ext_data;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          wb_valid_o <= 1'b0;
          err_o      <= 1'b0;
          rd_wr_en_o <= 1'b0;
          wb_data_o  <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040237_lsu
// Directed self-checking bench for the load/store unit. A driver task plays
// the execute stage and a simple memory (configurable ready delay, response
// one cycle after accept); per-scenario tasks compare against hand-computed
// values.
// ---------------------------------------------------------------------------
module tb_ysyx_22040237_lsu;

  logic        clk;
  logic        rst;
  logic        ls_valid_i;
  logic [6:0]  ls_info_bus_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic        rd_wr_en_i;
  logic [4:0]  rd_idx_i;
  logic        stall_o;
  logic        wb_valid_o;
  logic        rd_wr_en_o;
  logic [4:0]  rd_idx_o;
  logic [63:0] wb_data_o;
  logic        err_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_req_we_o;
  logic [63:0] mem_req_addr_o;
  logic [63:0] mem_req_wdata_o;
  logic [7:0]  mem_req_wstrb_o;
  logic        mem_rsp_valid_i;
  logic [63:0] mem_rsp_rdata_i;

  ysyx_22040237_lsu #(.XLEN(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .ls_valid_i      (ls_valid_i),
    .ls_info_bus_i   (ls_info_bus_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .rd_wr_en_i      (rd_wr_en_i),
    .rd_idx_i        (rd_idx_i),
    .stall_o         (stall_o),
    .wb_valid_o      (wb_valid_o),
    .rd_wr_en_o      (rd_wr_en_o),
    .rd_idx_o        (rd_idx_o),
    .wb_data_o       (wb_data_o),
    .err_o           (err_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_we_o    (mem_req_we_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wdata_o (mem_req_wdata_o),
    .mem_req_wstrb_o (mem_req_wstrb_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_rdata_i (mem_rsp_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Info bus encodings {dw,word,half,byte,usign,store,load}.
  localparam logic [6:0] I_SW  = 7'h22;
  localparam logic [6:0] I_SB  = 7'h0A;
  localparam logic [6:0] I_SH  = 7'h12;
  localparam logic [6:0] I_LB  = 7'h09;
  localparam logic [6:0] I_LHU = 7'h15;
  localparam logic [6:0] I_LW  = 7'h21;
  localparam logic [6:0] I_LWU = 7'h25;
  localparam logic [6:0] I_LD  = 7'h41;

  int passed = 0;
  int total  = 0;

  // Results of the last do_access call.
  int          r_stall, r_wb_cycle;
  logic        r_req_seen, r_stable, r_we, r_err, r_rd_en, r_stall_done, r_wb_after;
  logic [63:0] r_addr, r_wdata, r_wb_data;
  logic [7:0]  r_wstrb;
  logic [4:0]  r_rd_idx;

  // Called just after a rising edge with the DUT idle. Presents one request
  // for a single cycle, then scrambles the execute-side inputs to show they
  // are not re-sampled. The memory holds ready low for ready_wait cycles of
  // a valid request and responds the cycle after accept.
  task automatic do_access(input logic [6:0] info, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic rd_en,
                           input logic [4:0] rd_idx, input int ready_wait,
                           input logic [63:0] rdata);
    int   waited;
    logic accepted;
    waited = 0;
    r_stall = 0; r_wb_cycle = -1; r_req_seen = 1'b0; r_stable = 1'b1;
    r_addr = '0; r_wdata = '0; r_wstrb = '0; r_we = 1'b0;
    r_wb_data = '0; r_err = 1'b0; r_rd_en = 1'b0; r_rd_idx = '0;
    r_stall_done = 1'b1; r_wb_after = 1'b1;
    ls_valid_i = 1'b1; ls_info_bus_i = info; addr_i = addr; wdata_i = wdata;
    rd_wr_en_i = rd_en; rd_idx_i = rd_idx;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = rdata;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (wb_valid_o) begin
        r_wb_cycle = c; r_wb_data = wb_data_o; r_err = err_o;
        r_rd_en = rd_wr_en_o; r_rd_idx = rd_idx_o; r_stall_done = stall_o;
        break;
      end
      if (stall_o) r_stall++;
      if (mem_req_valid_o) begin
        if (!r_req_seen) begin
          r_addr = mem_req_addr_o; r_wdata = mem_req_wdata_o;
          r_wstrb = mem_req_wstrb_o; r_we = mem_req_we_o;
        end else if (r_addr !== mem_req_addr_o || r_wdata !== mem_req_wdata_o ||
                     r_wstrb !== mem_req_wstrb_o || r_we !== mem_req_we_o) begin
          r_stable = 1'b0;
        end
        r_req_seen = 1'b1;
        if (waited >= ready_wait) mem_req_ready_i = 1'b1;
        else begin mem_req_ready_i = 1'b0; waited++; end
      end else begin
        mem_req_ready_i = 1'b0;
      end
      #1;
      accepted = mem_req_valid_o & mem_req_ready_i;
      @(posedge clk); #1;
      ls_valid_i = 1'b0;
      addr_i = ~addr; wdata_i = ~wdata; rd_idx_i = ~rd_idx; rd_wr_en_i = ~rd_en;
      ls_info_bus_i = I_SW;
      mem_rsp_valid_i = accepted;
      mem_req_ready_i = 1'b0;
    end
    mem_rsp_valid_i = 1'b0;
    @(posedge clk); #1;
    r_wb_after = wb_valid_o;
  endtask

  task automatic test_reset;
    total++; if ({wb_valid_o, err_o, rd_wr_en_o, rd_idx_o, wb_data_o, mem_req_valid_o,
                  mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_wstrb_o} !== '0)
      $display("FAIL reset_outputs: wb_valid=%b err=%b req_valid=%b wb_data=%h, all required 0",
               wb_valid_o, err_o, mem_req_valid_o, wb_data_o);
    else passed++;
    total++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o); else passed++;
  endtask

  task automatic test_store_word;
    do_access(I_SW, 64'h8000_0004, 64'hDEAD_BEEF, 1'b1, 5'd5, 0, 64'h0);
    total++; if (r_addr !== 64'h8000_0000) $display("FAIL sw_addr: got %h want %h", r_addr, 64'h8000_0000); else passed++;
    total++; if (r_wstrb !== 8'hF0) $display("FAIL sw_wstrb: got %h want f0", r_wstrb); else passed++;
    total++; if (r_wdata !== 64'hDEAD_BEEF_0000_0000) $display("FAIL sw_wdata: got %h want deadbeef00000000", r_wdata); else passed++;
    total++; if (r_we !== 1'b1) $display("FAIL sw_we: got %b want 1", r_we); else passed++;
    total++; if (r_wb_cycle !== 3) $display("FAIL sw_latency: got %0d want 3", r_wb_cycle); else passed++;
    total++; if (r_stall !== 3) $display("FAIL sw_stall_cycles: got %0d want 3", r_stall); else passed++;
    total++; if (r_rd_en !== 1'b0) $display("FAIL sw_rd_wr_en: got %b want 0", r_rd_en); else passed++;
    total++; if (r_wb_data !== 64'h0) $display("FAIL sw_wb_data: got %h want 0", r_wb_data); else passed++;
    total++; if (r_stall_done !== 1'b0) $display("FAIL sw_stall_in_done: got %b want 0", r_stall_done); else passed++;
    total++; if (r_wb_after !== 1'b0) $display("FAIL sw_wb_pulse: got %b want 0 after done", r_wb_after); else passed++;
  endtask

  task automatic test_store_lanes;
    do_access(I_SB, 64'h1000_0005, 64'h0000_0000_0000_00AB, 1'b0, 5'd0, 0, 64'h0);
    total++; if (r_wstrb !== 8'h20) $display("FAIL sb_wstrb: got %h want 20", r_wstrb); else passed++;
    total++; if (r_wdata !== 64'h0000_AB00_0000_0000) $display("FAIL sb_wdata: got %h want 0000ab0000000000", r_wdata); else passed++;
    do_access(I_SH, 64'h1000_0002, 64'h0000_0000_0000_1234, 1'b0, 5'd0, 0, 64'h0);
    total++; if (r_wstrb !== 8'h0C) $display("FAIL sh_wstrb: got %h want 0c", r_wstrb); else passed++;
    total++; if (r_wdata !== 64'h0000_0000_1234_0000) $display("FAIL sh_wdata: got %h want 0000000012340000", r_wdata); else passed++;
  endtask

  task automatic test_loads;
    do_access(I_LB, 64'h8000_0003, 64'h0, 1'b1, 5'd10, 0, 64'h0000_0000_8000_0000);
    total++; if (r_wb_data !== 64'hFFFF_FFFF_FFFF_FF80) $display("FAIL lb_data: got %h want ffffffffffffff80", r_wb_data); else passed++;
    total++; if (r_rd_en !== 1'b1 || r_rd_idx !== 5'd10) $display("FAIL lb_rd: got en=%b idx=%0d want en=1 idx=10", r_rd_en, r_rd_idx); else passed++;
    total++; if (r_wstrb !== 8'h00 || r_we !== 1'b0 || r_addr !== 64'h8000_0000)
      $display("FAIL lb_req: got wstrb=%h we=%b addr=%h want 00 0 80000000", r_wstrb, r_we, r_addr); else passed++;
    do_access(I_LHU, 64'h6, 64'h0, 1'b1, 5'd3, 0, 64'hABCD_0000_0000_0000);
    total++; if (r_wb_data !== 64'h0000_0000_0000_ABCD) $display("FAIL lhu_data: got %h want 000000000000abcd", r_wb_data); else passed++;
    do_access(I_LW, 64'h4, 64'h0, 1'b1, 5'd7, 0, 64'h89AB_CDEF_0000_0000);
    total++; if (r_wb_data !== 64'hFFFF_FFFF_89AB_CDEF) $display("FAIL lw_data: got %h want ffffffff89abcdef", r_wb_data); else passed++;
    do_access(I_LWU, 64'h4, 64'h0, 1'b1, 5'd7, 0, 64'h89AB_CDEF_0000_0000);
    total++; if (r_wb_data !== 64'h0000_0000_89AB_CDEF) $display("FAIL lwu_data: got %h want 0000000089abcdef", r_wb_data); else passed++;
  endtask

  task automatic test_backpressure;
    do_access(I_LD, 64'h8000_0010, 64'h0, 1'b1, 5'd31, 4, 64'hF123_4567_89AB_CDEF);
    total++; if (r_stable !== 1'b1) $display("FAIL ld_req_stable: got %b want 1", r_stable); else passed++;
    total++; if (r_stall !== 7) $display("FAIL ld_stall_cycles: got %0d want 7", r_stall); else passed++;
    total++; if (r_wb_cycle !== 7) $display("FAIL ld_latency: got %0d want 7", r_wb_cycle); else passed++;
    total++; if (r_wb_data !== 64'hF123_4567_89AB_CDEF) $display("FAIL ld_data: got %h want f123456789abcdef", r_wb_data); else passed++;
    total++; if (r_addr !== 64'h8000_0010) $display("FAIL ld_addr: got %h want 80000010", r_addr); else passed++;
    total++; if (r_rd_idx !== 5'd31) $display("FAIL ld_rd_idx: got %0d want 31", r_rd_idx); else passed++;
  endtask

  task automatic test_errors;
    do_access(I_LW, 64'h2, 64'h0, 1'b1, 5'd4, 0, 64'h0);
    total++; if (r_err !== 1'b1) $display("FAIL lw_mis_err: got %b want 1", r_err); else passed++;
    total++; if (r_req_seen !== 1'b0) $display("FAIL lw_mis_noreq: got %b want 0", r_req_seen); else passed++;
    total++; if (r_rd_en !== 1'b0) $display("FAIL lw_mis_rd_en: got %b want 0", r_rd_en); else passed++;
    total++; if (r_wb_cycle !== 1 || r_stall !== 1) $display("FAIL lw_mis_timing: got wb=%0d stall=%0d want 1 1", r_wb_cycle, r_stall); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL lw_mis_err_pulse: got %b want 0", err_o); else passed++;
    do_access(7'h29, 64'h0, 64'h0, 1'b1, 5'd4, 0, 64'h0);
    total++; if (r_err !== 1'b1 || r_req_seen !== 1'b0 || r_rd_en !== 1'b0)
      $display("FAIL multi_size: got err=%b req=%b rd_en=%b want 1 0 0", r_err, r_req_seen, r_rd_en); else passed++;
    do_access(7'h0B, 64'h0, 64'h0, 1'b1, 5'd4, 0, 64'h0);
    total++; if (r_err !== 1'b1 || r_req_seen !== 1'b0) $display("FAIL load_store: got err=%b req=%b want 1 0", r_err, r_req_seen); else passed++;
    // Valid with neither load nor store must be ignored.
    ls_valid_i = 1'b1; ls_info_bus_i = 7'h20; addr_i = 64'h0; #1;
    total++; if (stall_o !== 1'b0) $display("FAIL nop_stall: got %b want 0", stall_o); else passed++;
    @(posedge clk); #1; ls_valid_i = 1'b0;
    total++; if (mem_req_valid_o !== 1'b0 || wb_valid_o !== 1'b0)
      $display("FAIL nop_ignored: got req=%b wb=%b want 0 0", mem_req_valid_o, wb_valid_o); else passed++;
  endtask

  task automatic test_reset_mid;
    ls_valid_i = 1'b1; ls_info_bus_i = I_LD; addr_i = 64'h8; rd_wr_en_i = 1'b1; rd_idx_i = 5'd9;
    mem_req_ready_i = 1'b1; mem_rsp_rdata_i = 64'h1111_2222_3333_4444;
    @(posedge clk); #1; ls_valid_i = 1'b0;          // REQ, accepted at next edge
    @(posedge clk); #1; mem_req_ready_i = 1'b0;     // RSP
    rst = 1'b1; mem_rsp_valid_i = 1'b1;
    @(posedge clk); #1;
    total++; if ({wb_valid_o, err_o, rd_wr_en_o, rd_idx_o, wb_data_o, mem_req_valid_o,
                  mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_wstrb_o, stall_o} !== '0)
      $display("FAIL mid_reset_outputs: wb_valid=%b req_valid=%b addr=%h stall=%b, all required 0",
               wb_valid_o, mem_req_valid_o, mem_req_addr_o, stall_o);
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;                              // late response while IDLE
    total++; if (wb_valid_o !== 1'b0) $display("FAIL late_rsp_ignored: got %b want 0", wb_valid_o); else passed++;
    mem_rsp_valid_i = 1'b0;
    do_access(I_LD, 64'h8, 64'h0, 1'b1, 5'd9, 0, 64'h5555_6666_7777_8888);
    total++; if (r_wb_data !== 64'h5555_6666_7777_8888 || r_wb_cycle !== 3)
      $display("FAIL post_reset_ld: got data=%h wb=%0d want 5555666677778888 3", r_wb_data, r_wb_cycle); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ls_valid_i = 1'b0; ls_info_bus_i = '0; addr_i = '0; wdata_i = '0;
    rd_wr_en_i = 1'b0; rd_idx_i = '0; mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    test_store_word;
    test_store_lanes;
    test_loads;
    test_backpressure;
    test_errors;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
